// File: rtl/sloth_seq_core.sv
// sloth_seq_core: sequential evaluator for straight-line register programs.
// One instruction {op, dst, src} per clock over an NREG x WIDTH register file.
`default_nettype none

module sloth_seq_core #(
   parameter  int WIDTH = 16,
   parameter  int NREG  = 4,
   parameter  int DEPTH = 16,
   localparam int RB    = $clog2(NREG),
   localparam int AB    = $clog2(DEPTH),
   localparam int IW    = 3 + RB + (RB + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  prog_we,
   input  logic [AB-1:0]         prog_addr,
   input  logic [IW-1:0]         prog_data,
   input  logic [AB:0]           prog_len,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NREG*WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [NREG*WIDTH-1:0] out_data,
   output logic                  busy
);

   localparam logic [AB:0] DEPTH_W = (AB+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t             state;
   logic [IW-1:0]      mem [DEPTH];
   logic [WIDTH-1:0]   r   [NREG];
   logic [WIDTH-1:0]   q   [NREG];
   logic [AB-1:0]      pc;
   logic [AB:0]        len;

   logic [IW-1:0]      instr;
   logic [2:0]         op;
   logic [RB-1:0]      dst;
   logic [RB:0]        src;
   logic [WIDTH-1:0]   s_val;
   logic [WIDTH-1:0]   d_val;
   logic [WIDTH-1:0]   alu;
   logic [AB:0]        len_sat;
   logic [AB:0]        pc_next;

   assign instr   = mem[pc];
   assign op      = instr[IW-1 -: 3];
   assign dst     = instr[RB+1 +: RB];
   assign src     = instr[RB:0];
   // Upper half of the source space selects the latched operand lanes.
   assign s_val   = src[RB] ? q[src[RB-1:0]] : r[src[RB-1:0]];
   assign d_val   = r[dst];
   assign len_sat = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
   assign pc_next = {1'b0, pc} + {{AB{1'b0}}, 1'b1};

   always_comb begin
      alu = d_val;
      case (op)
         3'd0: alu = s_val;
         3'd1: alu = d_val & s_val;
         3'd2: alu = d_val | s_val;
         3'd3: alu = d_val ^ s_val;
         3'd4: alu = {{(WIDTH-1){1'b0}}, (s_val == '0)};
         3'd5: alu = ~s_val;
         3'd6: alu = d_val + s_val;
         default: alu = d_val;
      endcase
   end

   // Program memory has no reset so a loaded program survives rst_n.
   always_ff @(posedge clk) begin
      if (prog_we && !busy)
         mem[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc        <= '0;
         len       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            r[i] <= '0;
            q[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < NREG; i++) begin
                     r[i] <= in_data[i*WIDTH +: WIDTH];
                     q[i] <= in_data[i*WIDTH +: WIDTH];
                  end
                  pc   <= '0;
                  len  <= len_sat;
                  busy <= 1'b1;
                  if (len_sat == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (op != 3'd7)
                  r[dst] <= alu;
               pc <= pc_next[AB-1:0];
               if (pc_next == len) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = rst_n && (state == IDLE);

   for (genvar g = 0; g < NREG; g++) begin : g_out
      assign out_data[g*WIDTH +: WIDTH] = r[g];
   end

endmodule

`default_nettype wire
